// File: rtl/conv_window_gen.sv
// +--------------------------------------------------------------------------+
// | conv_window_gen : raster pixel stream -> every valid KxK window, flattened |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
`default_nettype none

module conv_window_gen #(
  parameter int ROWS        = 20,
  parameter int COLS        = 20,
  parameter int KERNEL_SIZE = 3,
  parameter int DATA_W      = 16
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        in_valid,
  output logic                                        in_ready,
  input  logic [DATA_W-1:0]                           in_data,
  output logic                                        win_valid,
  input  logic                                        win_ready,
  output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_W-1:0]   win_data,
  output logic [$clog2(ROWS)-1:0]                     win_row,
  output logic [$clog2(COLS)-1:0]                     win_col,
  output logic                                        frame_done
);

  localparam int c_K     = KERNEL_SIZE;
  localparam int c_WIN_W = c_K * c_K * DATA_W;
  localparam int c_RW    = $clog2(ROWS);
  localparam int c_CW    = $clog2(COLS);

  typedef enum logic [1:0] {
    S_FILL   = 2'd0,
    S_STREAM = 2'd1
  } state_t;

  state_t                 state_q;
  logic [c_RW-1:0]        pix_row_q;
  logic [c_CW-1:0]        pix_col_q;
  logic [c_WIN_W-1:0]     sh_q;
  logic [c_WIN_W-1:0]     sh_d;
  logic                   win_valid_q;
  logic [c_WIN_W-1:0]     win_data_q;
  logic [c_RW-1:0]        win_row_q;
  logic [c_CW-1:0]        win_col_q;
  logic                   frame_done_q;
  logic [c_K*DATA_W-1:0]  w_newcol;

  logic w_accept, w_win_hs, w_row_last, w_col_last, w_complete;

  assign in_ready   = !win_valid_q || win_ready;
  assign w_accept   = in_valid && in_ready;
  assign w_win_hs   = win_valid_q && win_ready;
  assign w_row_last = (pix_row_q == c_RW'(ROWS - 1));
  assign w_col_last = (pix_col_q == c_CW'(COLS - 1));
  // In STREAM the row condition already holds; left columns of a row are masked here.
  assign w_complete = (state_q == S_STREAM) && (pix_col_q >= c_CW'(c_K - 1));

  generate
    if (c_K > 1) begin : g_lb
      logic [DATA_W-1:0] lb_q [c_K-1][COLS];

      always_ff @(posedge clk) begin
        if (w_accept) begin
          for (int i = 0; i < c_K - 2; i++) begin
            lb_q[i][pix_col_q] <= lb_q[i+1][pix_col_q];
          end
          lb_q[c_K-2][pix_col_q] <= in_data;
        end
      end

      for (genvar r = 0; r < c_K - 1; r++) begin : g_col
        assign w_newcol[r*DATA_W +: DATA_W] = lb_q[r][pix_col_q];
      end
    end
  endgenerate

  assign w_newcol[(c_K-1)*DATA_W +: DATA_W] = in_data;

  always_comb begin
    sh_d = '0;
    for (int r = 0; r < c_K; r++) begin
      for (int c = 0; c < c_K - 1; c++) begin
        sh_d[(r*c_K+c)*DATA_W +: DATA_W] = sh_q[(r*c_K+c+1)*DATA_W +: DATA_W];
      end
      sh_d[(r*c_K+c_K-1)*DATA_W +: DATA_W] = w_newcol[r*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= (c_K == 1) ? S_STREAM : S_FILL;
      pix_row_q    <= '0;
      pix_col_q    <= '0;
      sh_q         <= '0;
      win_valid_q  <= 1'b0;
      win_data_q   <= '0;
      win_row_q    <= '0;
      win_col_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      if (w_accept) begin
        sh_q <= sh_d;
        if (w_col_last) begin
          pix_col_q <= '0;
          pix_row_q <= w_row_last ? '0 : pix_row_q + c_RW'(1);
        end else begin
          pix_col_q <= pix_col_q + c_CW'(1);
        end
        if (c_K > 1) begin
          if (state_q == S_FILL && w_col_last && pix_row_q == c_RW'(c_K - 2)) begin
            state_q <= S_STREAM;
          end else if (state_q == S_STREAM && w_col_last && w_row_last) begin
            state_q <= S_FILL;
          end
        end
      end

      if (w_accept && w_complete) begin
        win_valid_q <= 1'b1;
        win_data_q  <= sh_d;
        win_row_q   <= pix_row_q - c_RW'(c_K - 1);
        win_col_q   <= pix_col_q - c_CW'(c_K - 1);
      end else if (w_win_hs) begin
        win_valid_q <= 1'b0;
      end

      frame_done_q <= w_win_hs && (win_row_q == c_RW'(ROWS - c_K))
                               && (win_col_q == c_CW'(COLS - c_K));
    end
  end

  assign win_valid  = win_valid_q;
  assign win_data   = win_data_q;
  assign win_row    = win_row_q;
  assign win_col    = win_col_q;
  assign frame_done = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_conv_window_gen.sv
// +--------------------------------------------------------------------------+
// | tb_conv_window_gen : scoreboard bench for conv_window_gen (5x5, 20x20, K=1) |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_conv_window_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        drv_valid;
  logic [15:0] drv_data;
  logic        win_ready = 1'b1;
  int          sel;

  // 5x5 K=3
  logic         iv5, rdy5, wv5, fd5;
  logic [143:0] wd5;
  logic [2:0]   row5, col5;
  // 20x20 K=3
  logic         iv20, rdy20, wv20, fd20;
  logic [143:0] wd20;
  logic [4:0]   row20, col20;
  // 3x3 K=1
  logic         ivk1, rdyk1, wvk1, fdk1;
  logic [15:0]  wdk1;
  logic [1:0]   rowk1, colk1;

  assign iv5  = drv_valid && (sel == 0);
  assign iv20 = drv_valid && (sel == 1);
  assign ivk1 = drv_valid && (sel == 2);

  conv_window_gen #(.ROWS(5), .COLS(5), .KERNEL_SIZE(3), .DATA_W(16)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv5), .in_ready(rdy5), .in_data(drv_data),
    .win_valid(wv5), .win_ready(win_ready), .win_data(wd5), .win_row(row5),
    .win_col(col5), .frame_done(fd5));

  conv_window_gen #(.ROWS(20), .COLS(20), .KERNEL_SIZE(3), .DATA_W(16)) u_dut20 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv20), .in_ready(rdy20), .in_data(drv_data),
    .win_valid(wv20), .win_ready(win_ready), .win_data(wd20), .win_row(row20),
    .win_col(col20), .frame_done(fd20));

  conv_window_gen #(.ROWS(3), .COLS(3), .KERNEL_SIZE(1), .DATA_W(16)) u_dutk1 (
    .clk(clk), .rst_n(rst_n), .in_valid(ivk1), .in_ready(rdyk1), .in_data(drv_data),
    .win_valid(wvk1), .win_ready(win_ready), .win_data(wdk1), .win_row(rowk1),
    .win_col(colk1), .frame_done(fdk1));

  logic         obs_rdy, obs_wv, obs_fd;
  logic [143:0] obs_wd;
  logic [4:0]   obs_row, obs_col;

  always_comb begin
    obs_rdy = rdy5; obs_wv = wv5; obs_fd = fd5; obs_wd = wd5;
    obs_row = 5'(row5); obs_col = 5'(col5);
    if (sel == 1) begin
      obs_rdy = rdy20; obs_wv = wv20; obs_fd = fd20; obs_wd = wd20;
      obs_row = row20; obs_col = col20;
    end else if (sel == 2) begin
      obs_rdy = rdyk1; obs_wv = wvk1; obs_fd = fdk1; obs_wd = 144'(wdk1);
      obs_row = 5'(rowk1); obs_col = 5'(colk1);
    end
  end

  typedef struct {
    logic [143:0] data;
    int           row;
    int           col;
    int           acc;
    bit           last;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_err    = 0;
  int          n_win    = 0;
  int          cyc      = 0;
  bit          lat_chk  = 1'b0;
  bit          fd_exp   = 1'b0;
  int          wr_mode  = 0;
  int          wr_idx   = 0;
  int          m_rows, m_cols, m_k, m_r, m_c;
  logic [15:0] img [20][20];

  task automatic check(input string tag, input logic [143:0] got, input logic [143:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Consumer: win_ready changes well after the edge so it is stable at every negedge.
  always @(posedge clk) begin
    #2;
    if (wr_mode == 1) begin
      win_ready = (wr_idx % 4 == 0) || (wr_idx % 4 == 3);
      wr_idx++;
    end else begin
      win_ready = 1'b1;
    end
  end

  task automatic set_model(input int r, input int c, input int k);
    m_rows = r; m_cols = c; m_k = k; m_r = 0; m_c = 0;
  endtask

  task automatic model_accept(input logic [15:0] d);
    exp_t e;
    img[m_r][m_c] = d;
    if (m_r >= m_k - 1 && m_c >= m_k - 1) begin
      e.data = '0;
      for (int i = 0; i < m_k; i++)
        for (int j = 0; j < m_k; j++)
          e.data[(i*m_k+j)*16 +: 16] = img[m_r-m_k+1+i][m_c-m_k+1+j];
      e.row  = m_r - m_k + 1;
      e.col  = m_c - m_k + 1;
      e.acc  = cyc;
      e.last = (e.row == m_rows - m_k) && (e.col == m_cols - m_k);
      sb.push_back(e);
    end
    if (m_c == m_cols - 1) begin
      m_c = 0;
      m_r = (m_r == m_rows - 1) ? 0 : m_r + 1;
    end else begin
      m_c++;
    end
  endtask

  task automatic send_px(input logic [15:0] d, input int gap_pct);
    int n;
    while ($urandom_range(99) < gap_pct) begin
      drv_valid = 1'b0;
      @(negedge clk);
    end
    drv_valid = 1'b1;
    drv_data  = d;
    n = 0;
    while (!obs_rdy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!obs_rdy) begin
      check("in_ready_timeout", 0, 1);
      drv_valid = 1'b0;
    end else begin
      model_accept(d);
      @(negedge clk);
      drv_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    #1;
    check("drain_empty", 144'(sb.size()), 0);
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst_n) begin
      fd_exp = 1'b0;
    end else begin
      if (fd_exp || obs_fd) check("frame_done", obs_fd, fd_exp);
      fd_exp = 1'b0;
      if (obs_wv && !win_ready) check("in_ready_stall", obs_rdy, 0);
      if (obs_wv && win_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_window", 1, 0);
        end else begin
          e = sb.pop_front();
          check("win_data", obs_wd, e.data);
          check("win_row", obs_row, 144'(e.row));
          check("win_col", obs_col, 144'(e.col));
          if (lat_chk) check("latency", 144'(cyc - e.acc), 1);
          fd_exp = e.last;
          n_win++;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    int w0;
    rst_n     = 1'b0;
    drv_valid = 1'b0;
    drv_data  = '0;
    sel       = 0;
    set_model(5, 5, 3);
    repeat (2) @(negedge clk);
    check("reset_in_ready", obs_rdy, 1);
    check("reset_win_valid", obs_wv, 0);
    check("reset_frame_done", obs_fd, 0);
    check("reset_win_data", obs_wd, 0);
    check("reset_win_row", obs_row, 0);
    check("reset_win_col", obs_col, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full-rate 5x5 frame
    lat_chk = 1'b1;
    w0 = n_win;
    for (int i = 0; i < 25; i++) send_px(16'(i), 0);
    drain();
    check("nwin_basic", 144'(n_win - w0), 9);

    // Backpressure 1,0,0,1
    lat_chk = 1'b0;
    wr_mode = 1;
    w0 = n_win;
    for (int i = 0; i < 25; i++) send_px(16'(i), 0);
    drain();
    check("nwin_stall", 144'(n_win - w0), 9);
    wr_mode = 0;
    repeat (2) @(negedge clk);

    // Back-to-back frames
    lat_chk = 1'b1;
    w0 = n_win;
    for (int i = 0; i < 25; i++) send_px(16'(i), 0);
    for (int i = 0; i < 25; i++) send_px(16'(100 + i), 0);
    drain();
    check("nwin_b2b", 144'(n_win - w0), 18);

    // Reset mid-frame after pixel 17
    for (int i = 0; i < 17; i++) send_px(16'(i), 0);
    drv_valid = 1'b1;
    drv_data  = 16'd17;
    model_accept(16'd17);
    @(posedge clk);
    #3;
    check("pre_reset_win_valid", obs_wv, 1);
    rst_n     = 1'b0;
    drv_valid = 1'b0;
    #1;
    check("midrst_win_valid", obs_wv, 0);
    check("midrst_frame_done", obs_fd, 0);
    check("midrst_in_ready", obs_rdy, 1);
    sb.delete();
    set_model(5, 5, 3);
    @(negedge clk);
    @(negedge clk);
    check("midrst_win_data", obs_wd, 0);
    check("midrst_win_row", obs_row, 0);
    rst_n = 1'b1;
    @(negedge clk);
    w0 = n_win;
    for (int i = 0; i < 25; i++) send_px(16'(i), 0);
    drain();
    check("nwin_after_reset", 144'(n_win - w0), 9);

    // 20x20 with random input gaps
    sel = 1;
    set_model(20, 20, 3);
    @(negedge clk);
    w0 = n_win;
    for (int i = 0; i < 400; i++) send_px(16'($urandom_range(65535)), 50);
    drain();
    check("nwin_random", 144'(n_win - w0), 324);

    // K=1, 3x3
    sel = 2;
    set_model(3, 3, 1);
    @(negedge clk);
    w0 = n_win;
    for (int i = 0; i < 9; i++) send_px(16'(200 + i), 0);
    drain();
    check("nwin_k1", 144'(n_win - w0), 9);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

`default_nettype wire
